// File: rtl/rng_pkg.sv
// rng_pkg: shared constants for random_range_gen.
// Holds the generator mode codes, the FSM state encodings and the
// maximal-length Galois tap masks (right-shift form) for widths 2..32.
package rng_pkg;
    localparam int MODE_COUNTER = 0;
    localparam int MODE_LFSR    = 1;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SAMPLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;
    // Bit i of the mask corresponds to the x^(i+1) term of the feedback polynomial.
    function automatic logic [31:0] taps(input int w);
        case (w)
            2:       taps = 32'h0000_0003;
            3:       taps = 32'h0000_0006;
            4:       taps = 32'h0000_000C;
            5:       taps = 32'h0000_0014;
            6:       taps = 32'h0000_0030;
            7:       taps = 32'h0000_0060;
            8:       taps = 32'h0000_00B8;
            9:       taps = 32'h0000_0110;
            10:      taps = 32'h0000_0240;
            11:      taps = 32'h0000_0500;
            12:      taps = 32'h0000_0E08;
            13:      taps = 32'h0000_1C80;
            14:      taps = 32'h0000_3802;
            15:      taps = 32'h0000_6000;
            16:      taps = 32'h0000_B400;
            17:      taps = 32'h0001_2000;
            18:      taps = 32'h0002_0400;
            19:      taps = 32'h0007_2000;
            20:      taps = 32'h0009_0000;
            21:      taps = 32'h0014_0000;
            22:      taps = 32'h0030_0000;
            23:      taps = 32'h0042_0000;
            24:      taps = 32'h00E1_0000;
            25:      taps = 32'h0120_0000;
            26:      taps = 32'h0200_0023;
            27:      taps = 32'h0400_0013;
            28:      taps = 32'h0900_0000;
            29:      taps = 32'h1400_0000;
            30:      taps = 32'h2000_0029;
            31:      taps = 32'h4800_0000;
            32:      taps = 32'h8020_0003;
            default: taps = 32'h0000_0000;
        endcase
    endfunction
endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: free-running generator state (up-counter or Galois LFSR) with seed loading.
// Ports: clk, rst (sync, active high), seed_load/seed (load, zero seed -> DEFAULT_SEED),
//        sample (low OUT_WIDTH bits of the registered state).
module lfsr_core import rng_pkg::*; #(
    parameter int          WIDTH        = 16,
    parameter int          OUT_WIDTH    = 3,
    parameter int          MODE         = MODE_LFSR,
    parameter logic [31:0] DEFAULT_SEED = 32'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 seed_load,
    input  logic [WIDTH-1:0]     seed,
    output logic [OUT_WIDTH-1:0] sample
);
    localparam logic [31:0]      TAPS_W = taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS   = TAPS_W[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED0  = DEFAULT_SEED[WIDTH-1:0];
    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] next;
    always_comb next = (MODE == MODE_COUNTER) ? state + 1'b1 : (state >> 1) ^ (state[0] ? TAPS : '0);
    always_ff @(posedge clk) begin
        if (rst)
            state <= SEED0;
        else if (seed_load)
            state <= (seed == '0) ? SEED0 : seed;
        else
            state <= next;
    end
    assign sample = state[OUT_WIDTH-1:0];
endmodule

// File: rtl/random_range_gen.sv
// random_range_gen: bounded random values 0..MAX_VALUE by rejection sampling with modulo fallback.
// Ports: clk, rst (sync, active high), seed_load/seed (generator reseed),
//        req/req_ready (request handshake), rand_valid/rand_ready/rand_value (result handshake),
//        reject_count (saturating count of rejected samples).
module random_range_gen import rng_pkg::*; #(
    parameter int          WIDTH        = 16,
    parameter int          OUT_WIDTH    = 3,
    parameter int          MAX_VALUE    = 3,
    parameter int          MODE         = MODE_LFSR,
    parameter int          MAX_TRIES    = 4,
    parameter logic [31:0] DEFAULT_SEED = 32'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 seed_load,
    input  logic [WIDTH-1:0]     seed,
    input  logic                 req,
    output logic                 req_ready,
    output logic                 rand_valid,
    input  logic                 rand_ready,
    output logic [OUT_WIDTH-1:0] rand_value,
    output logic [7:0]           reject_count
);
    // One extra bit keeps the bound comparison and modulus well-formed when MAX_VALUE is all ones.
    localparam logic [OUT_WIDTH:0] LIMIT = (OUT_WIDTH+1)'(MAX_VALUE);
    localparam logic [OUT_WIDTH:0] MODV  = (OUT_WIDTH+1)'(MAX_VALUE + 1);
    localparam logic [31:0]        LAST  = 32'(MAX_TRIES - 1);
    logic [1:0]           fsm;
    logic [31:0]          tries;
    logic [OUT_WIDTH-1:0] cand;
    logic                 reject;
    logic [OUT_WIDTH-1:0] folded;
    logic [7:0]           rc_next;
    lfsr_core #(
        .WIDTH(WIDTH),
        .OUT_WIDTH(OUT_WIDTH),
        .MODE(MODE),
        .DEFAULT_SEED(DEFAULT_SEED)
    ) u_core (
        .clk(clk),
        .rst(rst),
        .seed_load(seed_load),
        .seed(seed),
        .sample(cand)
    );
    always_comb begin
        reject  = {1'b0, cand} > LIMIT;
        folded  = OUT_WIDTH'({1'b0, cand} % MODV);
        rc_next = (reject_count == 8'hFF) ? reject_count : reject_count + 8'd1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm          <= ST_IDLE;
            tries        <= '0;
            rand_valid   <= 1'b0;
            rand_value   <= '0;
            reject_count <= '0;
        end else begin
            case (fsm)
                ST_IDLE: if (req) begin
                    fsm   <= ST_SAMPLE;
                    tries <= '0;
                end
                ST_SAMPLE: if (!reject) begin
                    rand_value <= cand;
                    rand_valid <= 1'b1;
                    fsm        <= ST_HOLD;
                end else begin
                    reject_count <= rc_next;
                    if (tries == LAST) begin
                        rand_value <= folded;
                        rand_valid <= 1'b1;
                        fsm        <= ST_HOLD;
                    end else begin
                        tries <= tries + 32'd1;
                    end
                end
                ST_HOLD: if (rand_ready) begin
                    rand_valid <= 1'b0;
                    fsm        <= ST_IDLE;
                end
                default: fsm <= ST_IDLE;
            endcase
        end
    end
    assign req_ready = (fsm == ST_IDLE);
endmodule

// File: tb/tb_random_range_gen.sv
// tb_random_range_gen: directed self-checking bench for random_range_gen and lfsr_core.
module tb_random_range_gen;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    always #5 clk = ~clk;

    logic        sl_a, req_a, rdy_a, rr_a, rv_a;
    logic [15:0] seed_a;
    logic [2:0]  val_a;
    logic [7:0]  rc_a;
    random_range_gen dut_a (
        .clk(clk), .rst(rst), .seed_load(sl_a), .seed(seed_a), .req(req_a),
        .req_ready(rr_a), .rand_valid(rv_a), .rand_ready(rdy_a),
        .rand_value(val_a), .reject_count(rc_a)
    );

    logic        req_b, rr_b, rv_b;
    logic [2:0]  val_b;
    logic [7:0]  rc_b;
    random_range_gen #(.WIDTH(3), .OUT_WIDTH(3), .MAX_VALUE(7), .MODE(0)) dut_b (
        .clk(clk), .rst(rst), .seed_load(1'b0), .seed(3'd0), .req(req_b),
        .req_ready(rr_b), .rand_valid(rv_b), .rand_ready(1'b1),
        .rand_value(val_b), .reject_count(rc_b)
    );

    logic        sl_c, req_c, rr_c, rv_c;
    logic [15:0] seed_c;
    logic [2:0]  val_c;
    logic [7:0]  rc_c;
    random_range_gen #(.MAX_VALUE(2), .MAX_TRIES(1)) dut_c (
        .clk(clk), .rst(rst), .seed_load(sl_c), .seed(seed_c), .req(req_c),
        .req_ready(rr_c), .rand_valid(rv_c), .rand_ready(1'b1),
        .rand_value(val_c), .reject_count(rc_c)
    );

    logic        sl_d;
    logic [15:0] seed_d, st_d;
    lfsr_core #(.WIDTH(16), .OUT_WIDTH(16), .MODE(1)) core_d (
        .clk(clk), .rst(rst), .seed_load(sl_d), .seed(seed_d), .sample(st_d)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        logic [2:0] exp_b;
        rst = 1'b1;
        sl_a = 1'b0; req_a = 1'b0; rdy_a = 1'b0; seed_a = '0;
        req_b = 1'b0;
        sl_c = 1'b0; req_c = 1'b0; seed_c = '0;
        sl_d = 1'b1; seed_d = 16'h1234;
        step(); step();
        check("rst_req_ready", 32'(rr_a), 32'd1);
        check("rst_valid", 32'(rv_a), 32'd0);
        check("rst_value", 32'(val_a), 32'd0);
        check("rst_rc", 32'(rc_a), 32'd0);
        check("rst_core_prio", 32'(st_d), 32'hACE1);
        rst = 1'b0; sl_d = 1'b0;
        step();
        check("core_adv", 32'(st_d), 32'hE270);
        sl_d = 1'b1; seed_d = 16'h0000;
        step();
        check("core_zero_seed", 32'(st_d), 32'hACE1);
        seed_d = 16'h0001;
        step();
        check("core_seed1", 32'(st_d), 32'h0001);
        sl_d = 1'b0;
        step();
        check("core_seed1_next", 32'(st_d), 32'hB400);

        sl_a = 1'b1; seed_a = 16'h0002; req_a = 1'b1;
        step();
        check("a1_sample_valid", 32'(rv_a), 32'd0);
        check("a1_sample_ready", 32'(rr_a), 32'd0);
        sl_a = 1'b0; req_a = 1'b0;
        step();
        check("a1_valid", 32'(rv_a), 32'd1);
        check("a1_value", 32'(val_a), 32'd2);
        check("a1_rc", 32'(rc_a), 32'd0);
        for (int i = 0; i < 10; i++) begin
            sl_a = i[0]; seed_a = 16'($urandom); req_a = 1'b1;
            step();
            check("hold_value", 32'(val_a), 32'd2);
            check("hold_valid", 32'(rv_a), 32'd1);
        end
        sl_a = 1'b0; req_a = 1'b0; rdy_a = 1'b1;
        step();
        check("release_valid", 32'(rv_a), 32'd0);
        check("release_ready", 32'(rr_a), 32'd1);
        rdy_a = 1'b0;

        sl_a = 1'b1; seed_a = 16'h0007; req_a = 1'b1;
        step();
        sl_a = 1'b0; req_a = 1'b0;
        step();
        check("a3_rej_valid", 32'(rv_a), 32'd0);
        check("a3_rej_rc", 32'(rc_a), 32'd1);
        step();
        check("a3_valid", 32'(rv_a), 32'd1);
        check("a3_value", 32'(val_a), 32'd3);
        rdy_a = 1'b1;
        step();
        rdy_a = 1'b0;

        sl_a = 1'b1; seed_a = 16'h00FF; req_a = 1'b1;
        step();
        sl_a = 1'b0; req_a = 1'b0;
        step(); step(); step();
        check("a4_pending_valid", 32'(rv_a), 32'd0);
        check("a4_pending_rc", 32'(rc_a), 32'd4);
        step();
        check("a4_fb_valid", 32'(rv_a), 32'd1);
        check("a4_fb_value", 32'(val_a), 32'd3);
        check("a4_fb_rc", 32'(rc_a), 32'd5);
        rdy_a = 1'b1;
        step();
        rdy_a = 1'b0;

        sl_a = 1'b1; seed_a = 16'h0002; req_a = 1'b1;
        step();
        check("a5_in_sample", 32'(rr_a), 32'd0);
        sl_a = 1'b0; req_a = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        check("a5_rst_valid", 32'(rv_a), 32'd0);
        check("a5_rst_ready", 32'(rr_a), 32'd1);
        check("a5_rst_rc", 32'(rc_a), 32'd0);

        sl_a = 1'b1; seed_a = 16'h0002; req_a = 1'b1;
        step();
        sl_a = 1'b0; req_a = 1'b0;
        step();
        check("a6_in_hold", 32'(rv_a), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("a6_rst_valid", 32'(rv_a), 32'd0);
        check("a6_rst_value", 32'(val_a), 32'd0);
        check("a6_rst_ready", 32'(rr_a), 32'd1);

        rst = 1'b1; req_b = 1'b1;
        step();
        rst = 1'b0;
        exp_b = 3'd2;
        for (int k = 1; k <= 12; k++) begin
            step();
            check("b_valid", 32'(rv_b), (k % 3 == 2) ? 32'd1 : 32'd0);
            if (k % 3 == 2) begin
                check("b_value", 32'(val_b), 32'(exp_b));
                exp_b = exp_b + 3'd3;
            end
        end
        check("b_rc", 32'(rc_b), 32'd0);
        req_b = 1'b0;

        rst = 1'b1;
        step();
        rst = 1'b0;
        sl_c = 1'b1; seed_c = 16'h0007; req_c = 1'b1;
        step();
        check("c_lat_valid", 32'(rv_c), 32'd0);
        sl_c = 1'b0; req_c = 1'b0;
        step();
        check("c_valid", 32'(rv_c), 32'd1);
        check("c_value", 32'(val_c), 32'd1);
        check("c_rc", 32'(rc_c), 32'd1);
        for (int i = 2; i <= 300; i++) begin
            step();
            sl_c = 1'b1; req_c = 1'b1;
            step();
            sl_c = 1'b0; req_c = 1'b0;
            step();
            if (i == 254) check("c_rc_254", 32'(rc_c), 32'd254);
        end
        check("c_rc_sat", 32'(rc_c), 32'd255);
        check("c_sat_value", 32'(val_c), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
